// File: rtl/std_div_iter_if.sv
// Request/response bundle for std_div_iter: operands, handshake strobes and registered results.
// No storage; pure wiring between a requester (master) and the divider (slave).
// Optional signed_op strobe exists only when STD_DIV_ITER_SIGNED_EN is defined.
interface std_div_iter_if #(
    parameter int width = 32
);
    logic [width-1:0] left;
    logic             left_read_in;
    logic [width-1:0] right;
    logic             right_read_in;
    logic             valid;
    logic             ready;
    logic [width-1:0] out_quotient;
    logic [width-1:0] out_remainder;
    logic             out_read_out;
    logic             busy;
`ifdef STD_DIV_ITER_SIGNED_EN
    logic             signed_op;
`endif

    modport master (
        output left, left_read_in, right, right_read_in, valid,
`ifdef STD_DIV_ITER_SIGNED_EN
        output signed_op,
`endif
        input  ready, out_quotient, out_remainder, out_read_out, busy
    );

    modport slave (
        input  left, left_read_in, right, right_read_in, valid,
`ifdef STD_DIV_ITER_SIGNED_EN
        input  signed_op,
`endif
        output ready, out_quotient, out_remainder, out_read_out, busy
    );
endinterface

// File: rtl/std_div_iter.sv
// Multi-cycle restoring divider, one quotient bit per cycle (signed mode with STD_DIV_ITER_SIGNED_EN).
// Latency: width+1 cycles from accept to ready pulse; 1 cycle for a zero divisor.
// Backpressure: none on the result (one-cycle ready pulse); requester holds valid, dropping it while busy aborts.
module std_div_iter #(
    parameter int width = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    std_div_iter_if.slave bus
);
    localparam int CW = $clog2(width + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [width-1:0] rem_q, rem_d;      // partial remainder, always < divisor
    logic [width-1:0] dvd_q, dvd_d;      // dividend shifts out MSB-first, quotient bits shift in
    logic [width-1:0] dvs_q, dvs_d;
    logic [width-1:0] quo_out_q, quo_out_d;
    logic [width-1:0] rem_out_q, rem_out_d;

    logic             start;
    logic [width:0]   shifted;           // width+1 bit trial value, cannot overflow
    logic             ge;
    logic [width-1:0] diff;
    logic [width-1:0] rem_next;
    logic [width-1:0] quo_next;
    logic [width-1:0] a_mag, b_mag;      // operands as fed to the unsigned core
    logic [width-1:0] q_fix, r_fix;      // final results after any sign correction

    assign start    = bus.valid && bus.left_read_in && bus.right_read_in;
    assign shifted  = {rem_q, dvd_q[width-1]};
    assign ge       = shifted >= {1'b0, dvs_q};
    // Result fits in width bits whenever ge holds, so the wrap of the narrow subtract is harmless.
    assign diff     = shifted[width-1:0] - dvs_q;
    assign rem_next = ge ? diff : shifted[width-1:0];
    assign quo_next = {dvd_q[width-2:0], ge};

`ifdef STD_DIV_ITER_SIGNED_EN
    logic qneg_q, qneg_d;
    logic rneg_q, rneg_d;
    logic a_neg, b_neg;

    assign a_neg = bus.signed_op && bus.left[width-1];
    assign b_neg = bus.signed_op && bus.right[width-1];
    assign a_mag = a_neg ? -bus.left  : bus.left;
    assign b_mag = b_neg ? -bus.right : bus.right;
    // Quotient sign is the XOR of operand signs; remainder follows the dividend.
    assign q_fix = qneg_q ? -quo_next : quo_next;
    assign r_fix = rneg_q ? -rem_next : rem_next;
`else
    assign a_mag = bus.left;
    assign b_mag = bus.right;
    assign q_fix = quo_next;
    assign r_fix = rem_next;
`endif

    // Next-state and datapath: accept in IDLE, iterate in BUSY, single-cycle DONE.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        quo_out_d = quo_out_q;
        rem_out_d = rem_out_q;
`ifdef STD_DIV_ITER_SIGNED_EN
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d = a_mag;
                    dvs_d = b_mag;
                    rem_d = '0;
                    cnt_d = CW'(width);
`ifdef STD_DIV_ITER_SIGNED_EN
                    qneg_d = a_neg ^ b_neg;
                    rneg_d = a_neg;
`endif
                    if (bus.right == '0) begin
                        // Divide by zero bypasses the iteration entirely.
                        state_d   = DONE;
                        quo_out_d = '1;
                        rem_out_d = bus.left;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (!bus.valid) begin
                    state_d = IDLE;
                end else begin
                    dvd_d = quo_next;
                    rem_d = rem_next;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d   = DONE;
                        quo_out_d = q_fix;
                        rem_out_d = r_fix;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, iteration registers and result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            quo_out_q <= '0;
            rem_out_q <= '0;
`ifdef STD_DIV_ITER_SIGNED_EN
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            quo_out_q <= quo_out_d;
            rem_out_q <= rem_out_d;
`ifdef STD_DIV_ITER_SIGNED_EN
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
`endif
        end
    end

    assign bus.ready         = (state_q == DONE);
    assign bus.out_read_out  = (state_q == DONE);
    assign bus.busy          = (state_q == BUSY);
    assign bus.out_quotient  = quo_out_q;
    assign bus.out_remainder = rem_out_q;
endmodule

// File: tb/tb_std_div_iter.sv
// Directed bench for std_div_iter at width 8 and width 32.
// Table-driven single operations plus hand-written abort, back-to-back and reset sequences.
// Signed cases are compiled in only with STD_DIV_ITER_SIGNED_EN.
module tb_std_div_iter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst8_n, rst32_n;

    std_div_iter_if #(.width(8))  dif8 ();
    std_div_iter_if #(.width(32)) dif32 ();

    std_div_iter #(.width(8))  dut8  (.clk(clk), .reset_n(rst8_n),  .bus(dif8));
    std_div_iter #(.width(32)) dut32 (.clk(clk), .reset_n(rst32_n), .bus(dif32));

    int nvec = 0;
    int nbad = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        bit         scr;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit w32, input logic [31:0] a, input logic [31:0] b, input bit v);
        if (w32) begin
            dif32.left = a; dif32.right = b;
            dif32.left_read_in = v; dif32.right_read_in = v; dif32.valid = v;
        end else begin
            dif8.left = a[7:0]; dif8.right = b[7:0];
            dif8.left_read_in = v; dif8.right_read_in = v; dif8.valid = v;
        end
    endtask

    // One full operation: accept, count cycles to ready (bounded), capture results, one idle cycle.
    task automatic run_op(input bit w32, input logic [31:0] a, input logic [31:0] b, input bit scramble,
                          output int lat, output int bcnt, output logic [31:0] q, output logic [31:0] r);
        lat = -1; bcnt = 0; q = '0; r = '0;
        drive(w32, a, b, 1'b1);
        @(posedge clk);
        for (int n = 1; n <= 80; n++) begin
            @(negedge clk);
            if (scramble && n == 3) drive(w32, ~a, 32'h0, 1'b1);
            if (w32 ? dif32.busy : dif8.busy) bcnt++;
            if (w32 ? dif32.ready : dif8.ready) begin
                lat = n;
                q = w32 ? dif32.out_quotient  : {24'h0, dif8.out_quotient};
                r = w32 ? dif32.out_remainder : {24'h0, dif8.out_remainder};
                chk("out_read_out", w32 ? dif32.out_read_out : dif8.out_read_out, 1);
                break;
            end
        end
        drive(w32, a, b, 1'b0);
        @(negedge clk);
    endtask

    initial begin
        int lat, bcnt, r1, r2, cnt;
        logic [31:0] q, r, q1, rm1, q2, rm2;

        tbl[0]  = '{8'd100, 8'd7,   8'd14,  8'd2,  1'b0};
        tbl[1]  = '{8'd5,   8'd0,   8'hFF,  8'd5,  1'b0};
        tbl[2]  = '{8'd200, 8'd3,   8'd66,  8'd2,  1'b0};
        tbl[3]  = '{8'd0,   8'd5,   8'd0,   8'd0,  1'b0};
        tbl[4]  = '{8'd7,   8'd9,   8'd0,   8'd7,  1'b0};
        tbl[5]  = '{8'd255, 8'd255, 8'd1,   8'd0,  1'b0};
        tbl[6]  = '{8'd128, 8'd16,  8'd8,   8'd0,  1'b0};
        tbl[7]  = '{8'd254, 8'd127, 8'd2,   8'd0,  1'b0};
        tbl[8]  = '{8'd0,   8'd0,   8'hFF,  8'd0,  1'b0};
        tbl[9]  = '{8'd255, 8'd2,   8'd127, 8'd1,  1'b0};
        tbl[10] = '{8'd37,  8'd5,   8'd7,   8'd2,  1'b1};
        tbl[11] = '{8'd1,   8'd1,   8'd1,   8'd0,  1'b0};

        rst8_n = 1'b0; rst32_n = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        drive(1'b1, 32'h0, 32'h0, 1'b0);
`ifdef STD_DIV_ITER_SIGNED_EN
        dif8.signed_op = 1'b0;
        dif32.signed_op = 1'b0;
`endif
        #1;
        chk("reset ready",     dif8.ready, 0);
        chk("reset busy",      dif8.busy, 0);
        chk("reset read_out",  dif8.out_read_out, 0);
        chk("reset quotient",  dif8.out_quotient, 0);
        chk("reset remainder", dif8.out_remainder, 0);
        repeat (2) @(negedge clk);
        rst8_n = 1'b1; rst32_n = 1'b1;
        @(negedge clk);

        // Table of single width-8 operations.
        for (int i = 0; i < 12; i++) begin
            run_op(1'b0, {24'h0, tbl[i].a}, {24'h0, tbl[i].b}, tbl[i].scr, lat, bcnt, q, r);
            chk($sformatf("v%0d latency", i),   lat,  (tbl[i].b == 0) ? 1 : 9);
            chk($sformatf("v%0d busy_cyc", i),  bcnt, (tbl[i].b == 0) ? 0 : 8);
            chk($sformatf("v%0d quotient", i),  q,    tbl[i].q);
            chk($sformatf("v%0d remainder", i), r,    tbl[i].r);
        end

        // Abort: drop valid after 4 busy cycles.
        drive(1'b0, 32'd200, 32'd3, 1'b1);
        @(posedge clk);
        cnt = 0;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            if (dif8.busy) cnt++;
        end
        chk("abort pre busy", cnt, 4);
        drive(1'b0, 32'd200, 32'd3, 1'b0);
        @(negedge clk);
        chk("abort busy low", dif8.busy, 0);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (dif8.ready) cnt++;
        end
        chk("abort no ready",  cnt, 0);
        chk("abort hold quo",  dif8.out_quotient,  tbl[11].q);
        chk("abort hold rem",  dif8.out_remainder, tbl[11].r);

        // Back-to-back with valid held across the DONE cycle.
        drive(1'b0, 32'd255, 32'd1, 1'b1);
        @(posedge clk);
        r1 = -1; r2 = -1; q1 = '0; rm1 = '0; q2 = '0; rm2 = '0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (dif8.ready) begin
                if (r1 < 0) begin
                    r1 = n; q1 = {24'h0, dif8.out_quotient}; rm1 = {24'h0, dif8.out_remainder};
                    drive(1'b0, 32'd17, 32'd4, 1'b1);
                end else begin
                    r2 = n; q2 = {24'h0, dif8.out_quotient}; rm2 = {24'h0, dif8.out_remainder};
                    break;
                end
            end
        end
        drive(1'b0, 32'd17, 32'd4, 1'b0);
        @(negedge clk);
        chk("b2b first ready",  r1,  9);
        chk("b2b second ready", r2,  19);
        chk("b2b q1",           q1,  255);
        chk("b2b r1",           rm1, 0);
        chk("b2b q2",           q2,  4);
        chk("b2b r2",           rm2, 1);

`ifdef STD_DIV_ITER_SIGNED_EN
        dif8.signed_op = 1'b1;
        run_op(1'b0, 32'hF9, 32'h02, 1'b0, lat, bcnt, q, r);
        chk("s -7/2 lat", lat, 9);
        chk("s -7/2 q",   q, 8'hFD);
        chk("s -7/2 r",   r, 8'hFF);
        run_op(1'b0, 32'h80, 32'hFF, 1'b0, lat, bcnt, q, r);
        chk("s -128/-1 q", q, 8'h80);
        chk("s -128/-1 r", r, 8'h00);
        run_op(1'b0, 32'h07, 32'hFE, 1'b0, lat, bcnt, q, r);
        chk("s 7/-2 q", q, 8'hFD);
        chk("s 7/-2 r", r, 8'h01);
        run_op(1'b0, 32'hF9, 32'h00, 1'b0, lat, bcnt, q, r);
        chk("s -7/0 lat", lat, 1);
        chk("s -7/0 q",   q, 8'hFF);
        chk("s -7/0 r",   r, 8'hF9);
        dif8.signed_op = 1'b0;
`endif

        // Width 32: establish a non-zero result, then reset mid-operation.
        run_op(1'b1, 32'd100, 32'd7, 1'b0, lat, bcnt, q, r);
        chk("w32 pre lat", lat,  33);
        chk("w32 pre bsy", bcnt, 32);
        chk("w32 pre q",   q,    14);
        chk("w32 pre r",   r,    2);
        drive(1'b1, 32'hFFFF_FFFF, 32'd3, 1'b1);
        @(posedge clk);
        repeat (10) @(negedge clk);
        chk("w32 busy before reset", dif32.busy, 1);
        rst32_n = 1'b0;
        #1;
        chk("w32 reset ready", dif32.ready, 0);
        chk("w32 reset busy",  dif32.busy, 0);
        chk("w32 reset quo",   dif32.out_quotient, 0);
        chk("w32 reset rem",   dif32.out_remainder, 0);
        drive(1'b1, 32'hFFFF_FFFF, 32'd3, 1'b0);
        @(negedge clk);
        rst32_n = 1'b1;
        @(negedge clk);
        run_op(1'b1, 32'hFFFF_FFFF, 32'd3, 1'b0, lat, bcnt, q, r);
        chk("w32 lat", lat,  33);
        chk("w32 bsy", bcnt, 32);
        chk("w32 q",   q,    32'h5555_5555);
        chk("w32 r",   r,    0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
